// File: rtl/imm_extend_pipe.sv
// Immediate decode/extend stage with branch-target add, registered output and
// a one-entry skid buffer so in_ready can be a flop.
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic [XLEN-1:0] PC,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] Target,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  logic [31:0]     imm32;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_tgt;

  always_comb begin
    imm32   = 32'h0;
    dec_ill = 1'b0;
    unique case (ImmSrc)
      3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
      3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'b010: imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                       Instr[11:8], 1'b0};
      3'b011: imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                       Instr[30:21], 1'b0};
      3'b100: imm32 = {Instr[31:12], 12'h000};
      3'b101: imm32 = {27'd0, Instr[19:15]};
      default: dec_ill = 1'b1;
    endcase
  end

  // Z-format leaves bit 31 clear, so one sign-extension path covers every format.
  if (XLEN == 64) begin : g_x64
    assign dec_imm = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign dec_imm = imm32;
  end

  assign dec_tgt = PC + dec_imm;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] out_tgt_q, out_tgt_d;
  logic            out_ill_q, out_ill_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] skid_tgt_q, skid_tgt_d;
  logic            skid_ill_q, skid_ill_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;
  logic            drain;

  assign accept = in_valid & in_ready_q & ~flush;
  assign drain  = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tgt_d    = out_tgt_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tgt_d   = skid_tgt_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; any new input backfills the skid.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tgt_d    = skid_tgt_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_imm_d = dec_imm;
          skid_tgt_d = dec_tgt;
          skid_ill_d = dec_ill;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_imm_d = dec_imm;
          out_tgt_d = dec_tgt;
          out_ill_d = dec_ill;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tgt_d   = dec_tgt;
      skid_ill_d   = dec_ill;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tgt_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tgt_q   <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tgt_q    <= out_tgt_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tgt_q   <= skid_tgt_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ImmExt    = out_imm_q;
  assign Target    = out_tgt_q;
  assign illegal   = out_ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: formats, backpressure, flush, async reset,
// plus an XLEN=64 instance for the 64-bit U-type extension.
module tb_imm_extend_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] pc, imm_ext, target;

  logic        in_valid64, in_ready64, out_valid64, illegal64;
  logic [31:0] instr64;
  logic [2:0]  imm_src64;
  logic [63:0] pc64, imm_ext64, target64;

  int pass_cnt  = 0;
  int total_cnt = 0;

  imm_extend_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(instr), .ImmSrc(imm_src), .PC(pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ImmExt(imm_ext),
    .Target(target), .illegal(illegal)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
    .Instr(instr64), .ImmSrc(imm_src64), .PC(pc64), .flush(1'b0),
    .out_valid(out_valid64), .out_ready(1'b1), .ImmExt(imm_ext64),
    .Target(target64), .illegal(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  // Presents one input for a single edge; caller sits at posedge+1.
  task automatic drive_one(input logic [31:0] i, input logic [2:0] s, input logic [31:0] p);
    in_valid = 1'b1; instr = i; imm_src = s; pc = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (imm_ext !== 32'h0) $display("FAIL reset_imm got=%h exp=0", imm_ext); else pass_cnt++;
    total_cnt++; if (target !== 32'h0) $display("FAIL reset_target got=%h exp=0", target); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal); else pass_cnt++;
  endtask

  task automatic test_formats;
    vec_t v[13];
    v[0]  = '{32'hFFF00093, 3'b000, 32'h100,      32'hFFFFFFFF, 32'h000000FF, 1'b0};
    v[1]  = '{32'h02000093, 3'b000, 32'hFFFFFFF0, 32'h00000020, 32'h00000010, 1'b0};
    v[2]  = '{32'hFE000E23, 3'b001, 32'h300,      32'hFFFFFFFC, 32'h000002FC, 1'b0};
    v[3]  = '{32'hFE000EE3, 3'b010, 32'h200,      32'hFFFFFFFC, 32'h000001FC, 1'b0};
    v[4]  = '{32'hFE000E63, 3'b010, 32'h200,      32'hFFFFF7FC, 32'hFFFFF9FC, 1'b0};
    v[5]  = '{32'h0080006F, 3'b011, 32'h1000,     32'h00000008, 32'h00001008, 1'b0};
    v[6]  = '{32'hFFDFF06F, 3'b011, 32'h1000,     32'hFFFFFFFC, 32'h00000FFC, 1'b0};
    v[7]  = '{32'h12345037, 3'b100, 32'h10,       32'h12345000, 32'h12345010, 1'b0};
    v[8]  = '{32'h800000B7, 3'b100, 32'h0,        32'h80000000, 32'h80000000, 1'b0};
    v[9]  = '{32'hFFF00093, 3'b110, 32'h40,       32'h00000000, 32'h00000040, 1'b1};
    v[10] = '{32'h800F8073, 3'b101, 32'h40,       32'h0000001F, 32'h0000005F, 1'b0};
    v[11] = '{32'hFFF00093, 3'b111, 32'h80,       32'h00000000, 32'h00000080, 1'b1};
    v[12] = '{32'h000F8073, 3'b101, 32'h0,        32'h0000001F, 32'h0000001F, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      drive_one(v[k].instr, v[k].src, v[k].pc);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL fmt%0d_valid got=%b exp=1", k, out_valid); else pass_cnt++;
      total_cnt++; if (imm_ext !== v[k].imm) $display("FAIL fmt%0d_imm got=%h exp=%h", k, imm_ext, v[k].imm); else pass_cnt++;
      total_cnt++; if (target !== v[k].tgt) $display("FAIL fmt%0d_target got=%h exp=%h", k, target, v[k].tgt); else pass_cnt++;
      total_cnt++; if (illegal !== v[k].ill) $display("FAIL fmt%0d_illegal got=%b exp=%b", k, illegal, v[k].ill); else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL fmt_drain_valid got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_u64;
    in_valid64 = 1'b1; instr64 = 32'h800000B7; imm_src64 = 3'b100; pc64 = 64'h1000;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    total_cnt++; if (out_valid64 !== 1'b1) $display("FAIL u64_valid got=%b exp=1", out_valid64); else pass_cnt++;
    total_cnt++; if (imm_ext64 !== 64'hFFFFFFFF80000000) $display("FAIL u64_imm got=%h exp=ffffffff80000000", imm_ext64); else pass_cnt++;
    total_cnt++; if (target64 !== 64'hFFFFFFFF80001000) $display("FAIL u64_target got=%h exp=ffffffff80001000", target64); else pass_cnt++;
    in_valid64 = 1'b1; instr64 = 32'hFFF00093; imm_src64 = 3'b000; pc64 = 64'h0;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    total_cnt++; if (target64 !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL i64_target got=%h exp=ffffffffffffffff", target64); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; instr = (k << 20) | 32'h93; imm_src = 3'b000; pc = 32'h1000;
      @(posedge clk); #1;
      total_cnt++; if (imm_ext !== k || out_valid !== 1'b1) $display("FAIL b2b%0d got v=%b imm=%h exp v=1 imm=%h", k, out_valid, imm_ext, k); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_in_ready got=%b exp=1", k, in_ready); else pass_cnt++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive_one(32'h00100093, 3'b000, 32'h0);  // A: imm 1
    drive_one(32'h00200093, 3'b000, 32'h0);  // B: imm 2
    in_valid = 1'b1; instr = 32'h00300093; imm_src = 3'b000; pc = 32'h0;  // C held by upstream
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low got=%b exp=0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || imm_ext !== 32'h1) $display("FAIL bp_hold_A got v=%b imm=%h exp v=1 imm=1", out_valid, imm_ext); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (imm_ext !== 32'h1 || target !== 32'h1) $display("FAIL bp_stable_A got imm=%h tgt=%h exp 1/1", imm_ext, target); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_C_blocked got in_ready=%b exp=0", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b1 || imm_ext !== 32'h2) $display("FAIL bp_B_second got v=%b imm=%h exp v=1 imm=2", out_valid, imm_ext); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_back got=%b exp=1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || imm_ext !== 32'h3) $display("FAIL bp_C_third got v=%b imm=%h exp v=1 imm=3", out_valid, imm_ext); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got v=%b imm=%h exp v=0", out_valid, imm_ext); else pass_cnt++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive_one(32'h00A00093, 3'b000, 32'h0);
    drive_one(32'h00B00093, 3'b000, 32'h0);
    in_valid = 1'b1; instr = 32'h00C00093; imm_src = 3'b000; pc = 32'h0; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_ghost%0d got v=%b imm=%h exp v=0", k, out_valid, imm_ext); else pass_cnt++;
    end
    // Flush with an idle output and a live input: the input must vanish.
    in_valid = 1'b1; instr = 32'h00D00093; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_same_cycle_input got v=%b exp=0", out_valid); else pass_cnt++;
    drive_one(32'h00E00093, 3'b000, 32'h0);
    total_cnt++; if (out_valid !== 1'b1 || imm_ext !== 32'hE) $display("FAIL flush_after got v=%b imm=%h exp v=1 imm=e", out_valid, imm_ext); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive_one(32'hFFF00093, 3'b000, 32'h100);
    drive_one(32'h00200093, 3'b000, 32'h0);
    total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL ar_pre got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (imm_ext !== 32'h0 || target !== 32'h0) $display("FAIL ar_data got imm=%h tgt=%h exp 0/0", imm_ext, target); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    drive_one(32'h00700093, 3'b000, 32'h8);
    total_cnt++; if (out_valid !== 1'b1 || imm_ext !== 32'h7 || target !== 32'hF) $display("FAIL ar_first_accept got v=%b imm=%h tgt=%h exp 1/7/f", out_valid, imm_ext, target); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_stale_entry got v=%b imm=%h exp v=0", out_valid, imm_ext); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'h0; imm_src = 3'b000; pc = 32'h0;
    in_valid64 = 1'b0; instr64 = 32'h0; imm_src64 = 3'b000; pc64 = 64'h0;
    #2;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    test_formats();
    test_u64();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
